data_ctrl: RTL and testbench

- Memory-side responder for the load buffer's request interface, and for committed stores from the reorder buffer.
- Accepts one load (address, width, signedness) or one store (address, width, data) at a time.
- Serialises the access into byte transfers on the 8-bit RAM/IO port, assembles and sign- or zero-extends load data, and returns it with a one-cycle valid pulse.
- Sits between lbuffer/rob and the top-level memory port.

---
 rtl/data_ctrl_pkg.sv | 17 +
 rtl/data_ctrl_load_extend.sv | 20 ++
 rtl/data_ctrl.sv | 127 ++++++++++++
 tb/tb_data_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_ctrl_pkg.sv
// data_ctrl_pkg: shared widths, width encodings, IO region base and FSM state codes for data_ctrl
package data_ctrl_pkg;
    localparam int AddressWidth = 32;
    localparam int IDWidth = 32;
    localparam logic [2:0] WidthNone = 3'b000;
    localparam logic [2:0] WidthByte = 3'b001;
    localparam logic [2:0] WidthHalf = 3'b010;
    localparam logic [2:0] WidthWord = 3'b100;
    localparam logic [AddressWidth-1:0] IOAddr = 32'h30000;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    // Byte count of a width code; any non-legal code counts as no request.
    function automatic logic [2:0] width_bytes(input logic [2:0] w);
        return w == WidthByte ? 3'd1 : w == WidthHalf ? 3'd2 : w == WidthWord ? 3'd4 : 3'd0;
    endfunction
endpackage

// File: rtl/data_ctrl_load_extend.sv
// data_ctrl_load_extend: sign/zero-extends assembled load bytes from bit 8N-1
//   raw   - assembled little-endian load bytes
//   width - load width code (byte/half/word)
//   sgn   - 1 sign-extends, 0 zero-extends
//   value - extended IDWidth result
module data_ctrl_load_extend
    import data_ctrl_pkg::*;
(
    input  logic [IDWidth-1:0] raw,
    input  logic [2:0]         width,
    input  logic               sgn,
    output logic [IDWidth-1:0] value
);
    logic fill;
    always_comb begin
        fill = sgn && (width == WidthByte ? raw[7] : width == WidthHalf ? raw[15] : raw[IDWidth-1]);
        value = width == WidthByte ? {{(IDWidth-8){fill}}, raw[7:0]} :
                width == WidthHalf ? {{(IDWidth-16){fill}}, raw[15:0]} : raw;
    end
endmodule

// File: rtl/data_ctrl.sv
// data_ctrl: serialises one load or committed store at a time onto the 8-bit RAM/IO port
//   clk_in, rst_in (async, active-low), rdy_in (global enable)
//   lbuffer_datactrl_*  - load request (addr, width, signed); datactrl_lbuffer_* - done pulse + data
//   rob_datactrl_*      - flush, committed store request (en, addr, width, data); datactrl_rob_ack_out - store done
//   io_buffer_full_in   - IO write buffer full, stalls stores to IOAddr / IOAddr+4
//   mem_din_in, mem_dout_out, mem_a_out, mem_wr_out - byte-wide memory port
module data_ctrl
    import data_ctrl_pkg::*;
(
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [AddressWidth-1:0] lbuffer_datactrl_addr_in,
    input  logic [2:0]              lbuffer_datactrl_width_in,
    input  logic                    lbuffer_datactrl_signed_in,
    output logic                    datactrl_lbuffer_en_out,
    output logic [IDWidth-1:0]      datactrl_lbuffer_data_out,
    input  logic                    rob_datactrl_rst_in,
    input  logic                    rob_datactrl_en_in,
    input  logic [AddressWidth-1:0] rob_datactrl_addr_in,
    input  logic [2:0]              rob_datactrl_width_in,
    input  logic [IDWidth-1:0]      rob_datactrl_data_in,
    output logic                    datactrl_rob_ack_out,
    input  logic                    io_buffer_full_in,
    input  logic [7:0]              mem_din_in,
    output logic [7:0]              mem_dout_out,
    output logic [AddressWidth-1:0] mem_a_out,
    output logic                    mem_wr_out
);
    logic [1:0]              state;
    logic [2:0]              k;
    logic [2:0]              wid;
    logic [2:0]              n;
    logic [1:0]              lane;
    logic [AddressWidth-1:0] addr;
    logic [IDWidth-1:0]      sdata;
    logic [IDWidth-1:0]      lbuf;
    logic [IDWidth-1:0]      asm;
    logic [IDWidth-1:0]      ext;
    logic                    sgn;
    logic                    turn;
    logic                    flush;
    logic                    io;
    logic                    stall;
    logic                    ld_drive;
    logic                    take_st;
    logic                    take_ld;

    data_ctrl_load_extend u_ext (
        .raw   (asm),
        .width (wid),
        .sgn   (sgn),
        .value (ext)
    );

    // The memory port is decoded from state so that idle, IO stalls and flushes show address 0 in the same cycle.
    always_comb begin
        n = width_bytes(wid);
        io = addr == IOAddr || addr == IOAddr + AddressWidth'(4);
        stall = state == STORE && io && io_buffer_full_in;
        flush = rdy_in && rob_datactrl_rst_in;
        ld_drive = state == LOAD && k < n && !flush;
        mem_wr_out = state == STORE && !stall && rdy_in;
        mem_a_out = ld_drive || mem_wr_out ? addr + AddressWidth'(k) : '0;
        mem_dout_out = mem_wr_out ? 8'(sdata >> {k[1:0], 3'b000}) : 8'h00;
        datactrl_rob_ack_out = mem_wr_out && k == n - 3'd1;
        lane = k[1:0] - 2'd1;
        asm = lbuf;
        asm[{lane, 3'b000} +: 8] = mem_din_in;
        take_st = rob_datactrl_en_in && width_bytes(rob_datactrl_width_in) != 3'd0;
        // Loads are held off while en is visible and for one cycle after, so lbuffer can retire the request.
        take_ld = width_bytes(lbuffer_datactrl_width_in) != 3'd0 && !datactrl_lbuffer_en_out && !turn && !rob_datactrl_rst_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
            k <= '0;
            wid <= '0;
            addr <= '0;
            sdata <= '0;
            lbuf <= '0;
            sgn <= 1'b0;
            turn <= 1'b0;
            datactrl_lbuffer_en_out <= 1'b0;
            datactrl_lbuffer_data_out <= '0;
        end else if (rdy_in) begin
            datactrl_lbuffer_en_out <= 1'b0;
            turn <= datactrl_lbuffer_en_out;
            if (state == IDLE) begin
                k <= '0;
                if (take_st) begin
                    state <= STORE;
                    addr <= rob_datactrl_addr_in;
                    wid <= rob_datactrl_width_in;
                    sdata <= rob_datactrl_data_in;
                end else if (take_ld) begin
                    state <= LOAD;
                    addr <= lbuffer_datactrl_addr_in;
                    wid <= lbuffer_datactrl_width_in;
                    sgn <= lbuffer_datactrl_signed_in;
                    lbuf <= '0;
                end
            end else if (state == LOAD) begin
                if (flush) begin
                    state <= IDLE;
                end else begin
                    if (k != 3'd0) lbuf <= asm;
                    if (k == n) begin
                        state <= IDLE;
                        datactrl_lbuffer_en_out <= 1'b1;
                        datactrl_lbuffer_data_out <= ext;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
            end else if (state == STORE) begin
                if (!stall) begin
                    k <= k + 3'd1;
                    if (k == n - 3'd1) state <= IDLE;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_data_ctrl.sv
// tb_data_ctrl: table-driven and sequence checks of data_ctrl against a byte RAM model and write/load scoreboards
module tb_data_ctrl;
    import data_ctrl_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  w;
        logic        s;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic [31:0] lb_addr = '0;
    logic [2:0]  lb_width = '0;
    logic        lb_signed = 1'b0;
    logic        en_out;
    logic [31:0] data_out;
    logic        rob_rst = 1'b0;
    logic        rob_en = 1'b0;
    logic [31:0] rob_addr = '0;
    logic [2:0]  rob_width = '0;
    logic [31:0] rob_data = '0;
    logic        ack_out;
    logic        io_full = 1'b0;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    logic [7:0]  ram [1024];
    logic [31:0] ldq [$];
    logic [39:0] wrq [$];
    vec_t        tv [$];
    int          total = 0;
    int          bad = 0;
    int          acks = 0;

    data_ctrl dut (
        .clk_in                     (clk_in),
        .rst_in                     (rst_in),
        .rdy_in                     (rdy_in),
        .lbuffer_datactrl_addr_in   (lb_addr),
        .lbuffer_datactrl_width_in  (lb_width),
        .lbuffer_datactrl_signed_in (lb_signed),
        .datactrl_lbuffer_en_out    (en_out),
        .datactrl_lbuffer_data_out  (data_out),
        .rob_datactrl_rst_in        (rob_rst),
        .rob_datactrl_en_in         (rob_en),
        .rob_datactrl_addr_in       (rob_addr),
        .rob_datactrl_width_in      (rob_width),
        .rob_datactrl_data_in       (rob_data),
        .datactrl_rob_ack_out       (ack_out),
        .io_buffer_full_in          (io_full),
        .mem_din_in                 (mem_din),
        .mem_dout_out               (mem_dout),
        .mem_a_out                  (mem_a),
        .mem_wr_out                 (mem_wr)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) mem_din <= ram[mem_a[9:0]];

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (en_out) begin
            if (ldq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ld_extra got=en data=%h want=no_en", data_out);
            end else chk("ld_data", {8'h00, data_out}, {8'h00, ldq.pop_front()});
        end
        if (mem_wr) begin
            if (wrq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_extra got=%h@%h want=no_write", mem_dout, mem_a);
            end else chk("wr", {mem_a, mem_dout}, wrq.pop_front());
        end
        if (ack_out) acks++;
        if (ack_out && en_out) begin
            total++;
            bad++;
            $display("FAIL en_ack_both got=1 want=0");
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic issue_load(input vec_t v);
        int c;
        for (int i = 0; i < 4; i++) ram[10'(v.a + 32'(i))] = v.b[8*i +: 8];
        tick();
        lb_addr = v.a;
        lb_width = v.w;
        lb_signed = v.s;
        ldq.push_back(v.e);
        tick();
        lb_width = 3'b000;
        @(negedge clk_in);
        chk("ld_a0", {8'h00, mem_a}, {8'h00, v.a});
        c = 0;
        while (!en_out && c < 20) begin
            tick();
            @(negedge clk_in);
            c++;
        end
        chk("ld_lat", 40'(c), 40'(v.lat));
        tick();
        lb_width = v.w;
        @(negedge clk_in);
        tick();
        lb_width = 3'b000;
        @(negedge clk_in);
        chk("ld_turn", {8'h00, mem_a}, 40'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, ack_c, en_c, a0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        tv.push_back('{32'h0000_0100, 3'b001, 1'b1, 32'h0000_0080, 32'hFFFF_FF80, 2});
        tv.push_back('{32'h0000_0100, 3'b001, 1'b0, 32'h0000_0080, 32'h0000_0080, 2});
        tv.push_back('{32'h0000_0200, 3'b100, 1'b0, 32'h4433_2211, 32'h4433_2211, 5});
        tv.push_back('{32'h0000_0010, 3'b010, 1'b1, 32'h0000_F234, 32'hFFFF_F234, 3});
        tv.push_back('{32'h0000_0010, 3'b010, 1'b0, 32'h0000_F234, 32'h0000_F234, 3});
        tv.push_back('{32'h0000_0020, 3'b010, 1'b1, 32'h0000_7FFF, 32'h0000_7FFF, 3});
        tv.push_back('{32'h0000_0300, 3'b100, 1'b1, 32'h8000_0000, 32'h8000_0000, 5});
        tv.push_back('{32'h0000_03FF, 3'b001, 1'b1, 32'h0000_007F, 32'h0000_007F, 2});
        tv.push_back('{32'hFFFF_FFFF, 3'b010, 1'b0, 32'h0000_CDAB, 32'h0000_CDAB, 3});

        @(negedge clk_in);
        chk("rst_a", {8'h00, mem_a}, 40'h0);
        chk("rst_wr", 40'(mem_wr), 40'h0);
        chk("rst_dout", 40'(mem_dout), 40'h0);
        chk("rst_en", 40'(en_out), 40'h0);
        chk("rst_data", {8'h00, data_out}, 40'h0);
        chk("rst_ack", 40'(ack_out), 40'h0);
        tick();
        tick();
        rst_in = 1'b1;
        @(negedge clk_in);

        foreach (tv[i]) issue_load(tv[i]);

        tick();
        lb_addr = 32'h100;
        lb_width = 3'b011;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 1) lb_width = 3'b111;
            @(negedge clk_in);
            chk("bad_width", {7'h00, mem_wr, mem_a}, 40'h0);
        end
        tick();
        lb_width = 3'b000;
        @(negedge clk_in);

        ram[10'h010] = 8'h34;
        ram[10'h011] = 8'hF2;
        tick();
        lb_addr = 32'h10;
        lb_width = 3'b010;
        lb_signed = 1'b1;
        rob_en = 1'b1;
        rob_addr = 32'h40;
        rob_width = 3'b100;
        rob_data = 32'hDEADBEEF;
        wrq.push_back({32'h40, 8'hEF});
        wrq.push_back({32'h41, 8'hBE});
        wrq.push_back({32'h42, 8'hAD});
        wrq.push_back({32'h43, 8'hDE});
        ldq.push_back(32'hFFFF_F234);
        ack_c = -1;
        en_c = -1;
        c = 0;
        while (en_c < 0 && c < 30) begin
            tick();
            if (ack_c >= 0) rob_en = 1'b0;
            @(negedge clk_in);
            if (ack_out && ack_c < 0) ack_c = c;
            if (en_out) en_c = c;
            c++;
        end
        tick();
        lb_width = 3'b000;
        @(negedge clk_in);
        chk("prio_ack_cyc", 40'(ack_c), 40'd3);
        chk("prio_en_cyc", 40'(en_c), 40'd8);

        tick();
        lb_addr = 32'h200;
        lb_width = 3'b100;
        tick();
        lb_width = 3'b000;
        @(negedge clk_in);
        chk("fl_a0", {8'h00, mem_a}, 40'h200);
        tick();
        @(negedge clk_in);
        chk("fl_a1", {8'h00, mem_a}, 40'h201);
        tick();
        rob_rst = 1'b1;
        @(negedge clk_in);
        chk("fl_a_now", {8'h00, mem_a}, 40'h0);
        tick();
        rob_rst = 1'b0;
        @(negedge clk_in);
        chk("fl_a_next", {8'h00, mem_a}, 40'h0);
        repeat (6) tick();
        lb_addr = 32'h100;
        lb_width = 3'b001;
        rob_rst = 1'b1;
        tick();
        lb_width = 3'b000;
        rob_rst = 1'b0;
        @(negedge clk_in);
        chk("fl_same_cyc", {8'h00, mem_a}, 40'h0);
        repeat (3) tick();
        @(negedge clk_in);
        issue_load(tv[2]);

        tick();
        rob_en = 1'b1;
        rob_addr = 32'h30000;
        rob_width = 3'b001;
        rob_data = 32'hFFFF_FF41;
        io_full = 1'b1;
        wrq.push_back({32'h30000, 8'h41});
        a0 = acks;
        for (int i = 0; i < 3; i++) begin
            tick();
            rob_rst = i == 1;
            @(negedge clk_in);
            chk("io_stall", {7'h00, mem_wr, mem_a}, 40'h0);
        end
        tick();
        io_full = 1'b0;
        rob_rst = 1'b0;
        @(negedge clk_in);
        chk("io_ack", 40'(ack_out), 40'h1);
        tick();
        rob_en = 1'b0;
        @(negedge clk_in);
        chk("io_ack_once", 40'(acks - a0), 40'h1);

        tick();
        rob_en = 1'b1;
        rob_addr = 32'h30008;
        rob_data = 32'h0000_005A;
        io_full = 1'b1;
        wrq.push_back({32'h30008, 8'h5A});
        tick();
        @(negedge clk_in);
        chk("nonio_ack", 40'(ack_out), 40'h1);
        tick();
        rob_en = 1'b0;
        rob_addr = 32'h30004;
        rob_width = 3'b010;
        rob_data = 32'h0000_1234;
        rob_en = 1'b1;
        wrq.push_back({32'h30004, 8'h34});
        wrq.push_back({32'h30005, 8'h12});
        tick();
        @(negedge clk_in);
        chk("io4_stall", {7'h00, mem_wr, mem_a}, 40'h0);
        tick();
        io_full = 1'b0;
        @(negedge clk_in);
        tick();
        @(negedge clk_in);
        chk("io4_ack", 40'(ack_out), 40'h1);
        tick();
        rob_en = 1'b0;
        @(negedge clk_in);

        tick();
        lb_addr = 32'h100;
        lb_width = 3'b001;
        lb_signed = 1'b1;
        ldq.push_back(32'hFFFF_FF80);
        tick();
        lb_width = 3'b000;
        rdy_in = 1'b0;
        rob_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("rdy_hold_a", {8'h00, mem_a}, 40'h100);
            tick();
        end
        rdy_in = 1'b1;
        rob_rst = 1'b0;
        c = 3;
        @(negedge clk_in);
        while (!en_out && c < 20) begin
            tick();
            @(negedge clk_in);
            c++;
        end
        chk("rdy_lat", 40'(c), 40'd5);
        tick();
        @(negedge clk_in);

        tick();
        lb_addr = 32'h200;
        lb_width = 3'b100;
        tick();
        lb_width = 3'b000;
        tick();
        #3;
        rst_in = 1'b0;
        #1;
        chk("arst_a", {8'h00, mem_a}, 40'h0);
        chk("arst_wr", 40'(mem_wr), 40'h0);
        chk("arst_en", 40'(en_out), 40'h0);
        chk("arst_data", {8'h00, data_out}, 40'h0);
        chk("arst_ack", 40'(ack_out), 40'h0);
        tick();
        tick();
        rst_in = 1'b1;
        repeat (8) tick();
        @(negedge clk_in);
        chk("arst_idle", {8'h00, mem_a}, 40'h0);
        issue_load(tv[3]);

        repeat (3) tick();
        @(negedge clk_in);
        chk("ldq_drained", 40'(ldq.size()), 40'h0);
        chk("wrq_drained", 40'(wrq.size()), 40'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
